// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters (stall_cnt, flush_cnt) are built when IF_ID_PERF_EN is defined.
module if_id_skid_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc_plus4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus4
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [PC_W-1:0]    main_pc, skid_pc;

  logic acc, drn;
  logic ld_main, ld_skid, shift;

  // Handshake flags come from the registered state only.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);

  assign out_instr    = out_valid ? main_instr : NOP_INSTR;
  assign out_pc_plus4 = out_valid ? main_pc : '0;

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    shift   = 1'b0;
    acc     = in_valid & in_ready;
    drn     = out_valid & out_ready;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d = S_ONE;
            ld_main = 1'b1;
          end
        end
        S_ONE: begin
          if (acc && !drn) begin
            state_d = S_FULL;
            ld_skid = 1'b1;
          end else if (acc) begin
            ld_main = 1'b1;
          end else if (drn) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (drn) begin
            state_d = S_ONE;
            shift   = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else begin
      if (ld_main) begin
        main_instr <= in_instr;
        main_pc    <= in_pc_plus4;
      end else if (shift) begin
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
      end
      if (ld_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc_plus4;
      end
    end
  end

`ifdef IF_ID_PERF_EN
  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
